// File: rtl/uart_cmd_bridge.sv
// Binary command bridge between uart FIFOs and a single-beat register bus.
// Frames: 0x57 ADDR DATA -> write (reply 0x4B); 0x52 ADDR -> read (reply data).
module uart_cmd_bridge #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 50000,
    parameter int TO_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_empty,
    input  logic [7:0]        r_data,
    output logic              rd_uart,
    input  logic              tx_full,
    output logic [7:0]        w_data,
    output logic              wr_uart,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_wdata,
    output logic              bus_we,
    output logic              bus_re,
    input  logic [7:0]        bus_rdata,
    output logic              busy,
    output logic [7:0]        err_cnt
);

    localparam logic [7:0]      OP_WR   = 8'h57;
    localparam logic [7:0]      OP_RD   = 8'h52;
    localparam logic [7:0]      RPL_ACK = 8'h4B;
    localparam logic [7:0]      RPL_BAD = 8'h3F;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        BUS_WR,
        BUS_RD,
        RD_WAIT,
        SEND
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_is_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata;
    logic [7:0]        r_reply;
    logic [7:0]        r_err_cnt;
    logic [TO_W-1:0]   r_to_cnt;

    logic              w_pop;
    logic              w_push;
    logic              w_timeout;
    logic              w_valid_op;
    logic              w_bad_op;

    assign w_valid_op = (r_data == OP_WR) || (r_data == OP_RD);

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_push    = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                w_pop = ~rx_empty;
                if (w_pop)
                    w_next = w_valid_op ? GET_ADDR : SEND;
            end
            GET_ADDR: begin
                w_pop = ~rx_empty;
                if (w_pop) begin
                    w_next = r_is_wr ? GET_DATA : BUS_RD;
                end else if (r_to_cnt == TO_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = IDLE;
                end
            end
            GET_DATA: begin
                w_pop = ~rx_empty;
                if (w_pop) begin
                    w_next = BUS_WR;
                end else if (r_to_cnt == TO_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = IDLE;
                end
            end
            BUS_WR:  w_next = SEND;
            BUS_RD:  w_next = RD_WAIT;
            RD_WAIT: w_next = SEND;
            SEND: begin
                w_push = ~tx_full;
                if (w_push)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_bad_op = (r_state == IDLE) && w_pop && !w_valid_op;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_is_wr   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_reply   <= '0;
            r_err_cnt <= '0;
            r_to_cnt  <= '0;
        end else begin
            if (r_state == IDLE && w_pop)
                r_is_wr <= (r_data == OP_WR);
            if (r_state == GET_ADDR && w_pop)
                r_addr <= r_data[ADDR_W-1:0];
            if (r_state == GET_DATA && w_pop)
                r_wdata <= r_data;

            if (w_bad_op)
                r_reply <= RPL_BAD;
            else if (r_state == BUS_WR)
                r_reply <= RPL_ACK;
            else if (r_state == RD_WAIT)
                r_reply <= bus_rdata;

            if (w_pop || w_next == IDLE)
                r_to_cnt <= '0;
            else if ((r_state == GET_ADDR || r_state == GET_DATA) && rx_empty)
                r_to_cnt <= r_to_cnt + 1'b1;

            if ((w_bad_op || w_timeout) && r_err_cnt != 8'hFF)
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    // FIFO strobes are gated by reset so data waiting in uart is never popped
    // or pushed while the bridge is held in reset.
    assign rd_uart   = reset & w_pop;
    assign wr_uart   = reset & w_push;
    assign bus_we    = (r_state == BUS_WR);
    assign bus_re    = (r_state == BUS_RD);
    assign busy      = (r_state != IDLE);
    assign w_data    = r_reply;
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Directed bench for uart_cmd_bridge: FIFO and bus models plus a linear
// sequence of frames with hand-computed replies (bus read data = addr ^ 0xF7).
module tb_uart_cmd_bridge;

    localparam int TIMEOUT = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic       tx_full = 1'b0;
    logic [7:0] w_data;
    logic       wr_uart;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_we;
    logic       bus_re;
    logic [7:0] bus_rdata = 8'h00;
    logic       busy;
    logic [7:0] err_cnt;

    logic [7:0] rx_mem [0:1023];
    int         rx_wp = 0;
    int         rx_rp = 0;

    int         cyc = 0;
    int         pops = 0;
    int         we_cnt = 0;
    int         re_cnt = 0;
    int         last_pop = 0;
    int         we_cyc = 0;
    int         re_cyc = 0;
    logic [7:0] we_addr = 8'h00;
    logic [7:0] we_data = 8'h00;
    logic [7:0] re_addr = 8'h00;
    int         pop_cyc [$];
    int         tx_cyc [$];
    logic [7:0] tx_dat [$];

    int         errors = 0;
    int         checks = 0;

    assign rx_empty = (rx_rp == rx_wp);
    assign r_data   = rx_mem[rx_rp[9:0]];

    uart_cmd_bridge #(
        .ADDR_W  (8),
        .TIMEOUT (TIMEOUT),
        .TO_W    (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_empty  (rx_empty),
        .r_data    (r_data),
        .rd_uart   (rd_uart),
        .tx_full   (tx_full),
        .w_data    (w_data),
        .wr_uart   (wr_uart),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_re    (bus_re),
        .bus_rdata (bus_rdata),
        .busy      (busy),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    // Event logger, RX FIFO read pointer and registered bus read model.
    always @(posedge clk) begin
        cyc++;
        if (rd_uart) begin
            pops++;
            last_pop = cyc;
            pop_cyc.push_back(cyc);
        end
        if (wr_uart) begin
            tx_dat.push_back(w_data);
            tx_cyc.push_back(cyc);
        end
        if (bus_we) begin
            we_cnt++;
            we_addr = bus_addr;
            we_data = bus_wdata;
            we_cyc  = cyc;
        end
        if (bus_re) begin
            re_cnt++;
            re_addr = bus_addr;
            re_cyc  = cyc;
            bus_rdata <= bus_addr ^ 8'hF7;
        end
        if (rd_uart)
            rx_rp <= rx_rp + 1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_rx(input logic [7:0] b);
        rx_mem[rx_wp[9:0]] = b;
        rx_wp++;
    endtask

    task automatic wait_tx(input int n, input int budget, input string tag);
        int k = 0;
        while (tx_dat.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, (tx_dat.size() >= n) ? 16'd1 : 16'd0, 16'd1);
    endtask

    task automatic wait_pops(input int n, input int budget, input string tag);
        int k = 0;
        while (pops < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, (pops >= n) ? 16'd1 : 16'd0, 16'd1);
    endtask

    initial begin
        int p0;
        int t0;

        // Reset with a write frame already waiting in the RX FIFO.
        push_rx(8'h57); push_rx(8'h12); push_rx(8'hA5);
        #1;
        check("rst_strobes", {11'd0, rd_uart, wr_uart, bus_we, bus_re, busy}, 16'd0);
        check("rst_w_data", {8'd0, w_data}, 16'h0000);
        check("rst_bus_addr", {8'd0, bus_addr}, 16'h0000);
        check("rst_bus_wdata", {8'd0, bus_wdata}, 16'h0000);
        check("rst_err_cnt", {8'd0, err_cnt}, 16'h0000);
        repeat (3) @(negedge clk);
        check("rst_no_pop", 16'(pops), 16'd0);
        reset = 1'b1;

        // Write frame 0x57 0x12 0xA5.
        wait_tx(1, 50, "wr_reply_seen");
        check("wr_pops", 16'(pops), 16'd3);
        check("wr_we_cnt", 16'(we_cnt), 16'd1);
        check("wr_addr", {8'd0, we_addr}, 16'h0012);
        check("wr_data", {8'd0, we_data}, 16'h00A5);
        check("wr_no_re", 16'(re_cnt), 16'd0);
        check("wr_reply", {8'd0, tx_dat[0]}, 16'h004B);
        check("wr_we_lat", 16'(we_cyc - last_pop), 16'd1);
        check("wr_tx_lat_min", (tx_cyc[0] - last_pop >= 2) ? 16'd1 : 16'd0, 16'd1);
        check("wr_idle", {15'd0, busy}, 16'd0);
        check("wr_addr_held", {8'd0, bus_addr}, 16'h0012);

        // Read frame 0x52 0x34 -> 0x34 ^ 0xF7 = 0xC3, reply 3 cycles after ADDR pop.
        push_rx(8'h52); push_rx(8'h34);
        wait_tx(2, 50, "rd_reply_seen");
        check("rd_re_cnt", 16'(re_cnt), 16'd1);
        check("rd_addr", {8'd0, re_addr}, 16'h0034);
        check("rd_no_we", 16'(we_cnt), 16'd1);
        check("rd_reply", {8'd0, tx_dat[1]}, 16'h00C3);
        check("rd_re_lat", 16'(re_cyc - pop_cyc[4]), 16'd1);
        check("rd_tx_lat", 16'(tx_cyc[1] - pop_cyc[4]), 16'd3);

        // Bad opcode 0x00 then read 0x52 0x01 -> 0x3F, then 0xF6; back-to-back pop.
        push_rx(8'h00); push_rx(8'h52); push_rx(8'h01);
        wait_tx(4, 50, "bad_replies_seen");
        check("bad_reply", {8'd0, tx_dat[2]}, 16'h003F);
        check("bad_next_reply", {8'd0, tx_dat[3]}, 16'h00F6);
        check("bad_err_cnt", {8'd0, err_cnt}, 16'h0001);
        check("b2b_pop_after_push", 16'(pop_cyc[6] - tx_cyc[2]), 16'd1);
        check("bad_tx_lat", 16'(tx_cyc[2] - pop_cyc[5]), 16'd1);

        // Opcode values in ADDR/DATA positions are raw data.
        push_rx(8'h57); push_rx(8'h52); push_rx(8'h57);
        wait_tx(5, 50, "raw_reply_seen");
        check("raw_reply", {8'd0, tx_dat[4]}, 16'h004B);
        check("raw_addr", {8'd0, we_addr}, 16'h0052);
        check("raw_data", {8'd0, we_data}, 16'h0057);
        check("raw_we_cnt", 16'(we_cnt), 16'd2);
        check("raw_re_cnt", 16'(re_cnt), 16'd2);

        // Timeout: 0x57 0x10 then silence; idle after exactly TIMEOUT empty cycles.
        p0 = pops;
        push_rx(8'h57); push_rx(8'h10);
        wait_pops(p0 + 2, 20, "to_pops");
        repeat (TIMEOUT - 1) @(negedge clk);
        check("to_still_busy", {15'd0, busy}, 16'd1);
        @(negedge clk);
        check("to_idle", {15'd0, busy}, 16'd0);
        check("to_err_cnt", {8'd0, err_cnt}, 16'h0002);
        check("to_no_we", 16'(we_cnt), 16'd2);
        check("to_no_reply", 16'(tx_dat.size()), 16'd5);
        push_rx(8'h52); push_rx(8'h10);
        wait_tx(6, 50, "to_after_seen");
        check("to_after_reply", {8'd0, tx_dat[5]}, 16'h00E7);
        check("to_after_err", {8'd0, err_cnt}, 16'h0002);

        // Backpressure: tx_full held 100 cycles during SEND; trailing byte must wait.
        tx_full = 1'b1;
        p0 = pops;
        push_rx(8'h52); push_rx(8'h34); push_rx(8'h00);
        wait_pops(p0 + 2, 20, "bp_pops");
        repeat (100) @(negedge clk);
        check("bp_no_extra_pop", 16'(pops - p0), 16'd2);
        check("bp_no_push", 16'(tx_dat.size()), 16'd6);
        check("bp_wr_low", {15'd0, wr_uart}, 16'd0);
        check("bp_busy", {15'd0, busy}, 16'd1);
        check("bp_w_data", {8'd0, w_data}, 16'h00C3);
        tx_full = 1'b0;
        wait_tx(8, 50, "bp_release_seen");
        repeat (3) @(negedge clk);
        check("bp_push_count", 16'(tx_dat.size()), 16'd8);
        check("bp_reply", {8'd0, tx_dat[6]}, 16'h00C3);
        check("bp_next_reply", {8'd0, tx_dat[7]}, 16'h003F);
        check("bp_err_cnt", {8'd0, err_cnt}, 16'h0003);

        // Reset mid-frame after 0x57 0x20; bytes arriving during reset wait.
        p0 = pops;
        push_rx(8'h57); push_rx(8'h20);
        wait_pops(p0 + 2, 20, "mr_pops");
        #2 reset = 1'b0;
        #1;
        check("mr_busy", {15'd0, busy}, 16'd0);
        check("mr_bus_addr", {8'd0, bus_addr}, 16'h0000);
        check("mr_err_cnt", {8'd0, err_cnt}, 16'h0000);
        check("mr_w_data", {8'd0, w_data}, 16'h0000);
        push_rx(8'h52); push_rx(8'h20);
        #1;
        check("mr_rd_low", {15'd0, rd_uart}, 16'd0);
        repeat (3) @(negedge clk);
        check("mr_no_pop", 16'(pops - p0), 16'd2);
        reset = 1'b1;
        wait_tx(9, 50, "mr_reply_seen");
        check("mr_reply", {8'd0, tx_dat[8]}, 16'h00D7);
        check("mr_re_addr", {8'd0, re_addr}, 16'h0020);
        check("mr_no_we", 16'(we_cnt), 16'd3 - 16'd1);

        // err_cnt saturation: 256 bad opcodes from zero stick at 255.
        t0 = tx_dat.size();
        for (int i = 0; i < 256; i++)
            push_rx(8'hFF);
        wait_tx(t0 + 256, 2000, "sat_replies_seen");
        check("sat_err_cnt", {8'd0, err_cnt}, 16'h00FF);
        check("sat_last_reply", {8'd0, tx_dat[t0 + 255]}, 16'h003F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
